// File: rtl/instr_fetch_unit_pkg.sv
// Shared encodings for the multicycle MIPS fetch front end.
// Fetch FSM states and PCSource selects live here so the control FSM can
// import the same values.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        F_IDLE = 2'b00,
        F_WAIT = 2'b01,
        F_DONE = 2'b10
    } fetch_state_e;

    typedef enum logic [1:0] {
        PCSRC_ALU_RESULT = 2'b00,
        PCSRC_ALU_OUT    = 2'b01,
        PCSRC_JUMP       = 2'b10,
        PCSRC_HOLD       = 2'b11
    } pc_src_e;

endpackage

// File: rtl/instr_fetch_unit_fetch_watchdog.sv
// fetch_watchdog: down-counter that flags a memory read which has been
// outstanding for TIMEOUT cycles. Used only in FETCH_TIMEOUT_EN builds.
module fetch_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic expired
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // Reload while idle; count down once per wait cycle, parking at zero
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            count <= LOAD;
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign expired = run && (count == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC and instruction register for a multicycle MIPS core,
// fetching over a variable-latency req/ack memory port.
// Optional feature: define FETCH_TIMEOUT_EN to abandon a fetch after TIMEOUT
// cycles without mem_ack (fetch_err pulses, instr is left unchanged).
//
// state  | meaning
// F_IDLE | no read outstanding; IRWrite starts a fetch from pc
// F_WAIT | mem_req high, waiting for mem_ack
// F_DONE | IR just loaded; fetch_done is raised from here
//
// fetch_done and fetch_err are registered pulses, so fetch_done is seen the
// cycle after F_DONE (IRWrite cycle 0, ack on first request cycle -> done at
// cycle 3).
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int           N        = 32,
    parameter logic [N-1:0] RESET_PC = '0,
    parameter int           TIMEOUT  = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         IRWrite,
    input  logic         PCWrite,
    input  logic         PCWriteCond,
    input  logic         Zero,
    input  logic [1:0]   PCSource,
    input  logic [N-1:0] alu_result,
    input  logic [N-1:0] alu_out,
    output logic         mem_req,
    output logic [N-1:0] mem_addr,
    input  logic         mem_ack,
    input  logic [N-1:0] mem_rdata,
    output logic [N-1:0] pc,
    output logic [N-1:0] instr,
    output logic [5:0]   Op_code,
    output logic [5:0]   Funct,
    output logic         fetch_busy,
    output logic         fetch_done,
    output logic         fetch_err
);
    fetch_state_e state, state_nxt;
    logic         pc_en;
    logic         start_fetch;
    logic         capture;
    logic         misalign;
    logic         timed_out;
    logic         expired;
    logic [N-1:0] pc_nxt;
    logic [N-1:0] jump_target;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("instr_fetch_unit: TIMEOUT must be at least 1");
    end

`ifdef FETCH_TIMEOUT_EN
    fetch_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .run     (state == F_WAIT),
        .expired (expired)
    );
`else
    assign expired = 1'b0;
`endif

    assign pc_en       = PCWrite | (PCWriteCond & Zero);
    assign jump_target = {pc[N-1:28], instr[25:0], 2'b00};

    // Next-PC source select; the jump target uses the IR as it stands now
    always_comb begin
        pc_nxt = pc;
        case (pc_src_e'(PCSource))
            PCSRC_ALU_RESULT: pc_nxt = alu_result;
            PCSRC_ALU_OUT:    pc_nxt = alu_out;
            PCSRC_JUMP:       pc_nxt = jump_target;
            PCSRC_HOLD:       pc_nxt = pc;
            default:          pc_nxt = pc;
        endcase
    end

    // Fetch FSM next state and the single-cycle actions of each transition
    always_comb begin
        state_nxt   = state;
        start_fetch = 1'b0;
        capture     = 1'b0;
        misalign    = 1'b0;
        timed_out   = 1'b0;
        case (state)
            F_IDLE: begin
                if (IRWrite) begin
                    if (pc[1:0] == 2'b00) begin
                        start_fetch = 1'b1;
                        state_nxt   = F_WAIT;
                    end else begin
                        misalign = 1'b1;
                    end
                end
            end
            F_WAIT: begin
                if (mem_ack) begin
                    capture   = 1'b1;
                    state_nxt = F_DONE;
                end else if (expired) begin
                    timed_out = 1'b1;
                    state_nxt = F_IDLE;
                end
            end
            F_DONE:  state_nxt = F_IDLE;
            default: state_nxt = F_IDLE;
        endcase
    end

    // State register, PC, IR, latched fetch address and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= F_IDLE;
            pc         <= RESET_PC;
            instr      <= '0;
            mem_addr   <= '0;
            fetch_done <= 1'b0;
            fetch_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (pc_en) begin
                pc <= pc_nxt;
            end
            if (start_fetch) begin
                mem_addr <= pc;
            end
            if (capture) begin
                instr <= mem_rdata;
            end
            fetch_done <= (state == F_DONE);
            fetch_err  <= misalign | timed_out;
        end
    end

    assign mem_req    = (state == F_WAIT);
    assign fetch_busy = (state == F_WAIT);
    assign Op_code    = instr[31:26];
    assign Funct      = instr[5:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a transaction-level reference model
// checked every cycle on the falling edge, plus hand-computed literal checks.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

    localparam int TIMEOUT = 4;
`ifdef FETCH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        IRWrite, PCWrite, PCWriteCond, Zero;
    logic [1:0]  PCSource;
    logic [31:0] alu_result, alu_out, mem_rdata;
    logic        mem_ack;
    logic        mem_req;
    logic [31:0] mem_addr, pc, instr;
    logic [5:0]  Op_code, Funct;
    logic        fetch_busy, fetch_done, fetch_err;

    int n_assert = 0;
    int n_fail   = 0;

    instr_fetch_unit #(
        .N        (32),
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .IRWrite     (IRWrite),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .Zero        (Zero),
        .PCSource    (PCSource),
        .alu_result  (alu_result),
        .alu_out     (alu_out),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .pc          (pc),
        .instr       (instr),
        .Op_code     (Op_code),
        .Funct       (Funct),
        .fetch_busy  (fetch_busy),
        .fetch_done  (fetch_done),
        .fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp1(input string nm, input logic act, input logic exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one read in flight at a time, tracked as a request
    // flag, a wait-cycle tally, and a "one cycle after the data" gap.
    logic [31:0] m_pc, m_instr, m_addr;
    bit          m_req, m_gap, m_done, m_err, m_valid;
    int          m_waited;

    initial m_valid = 1'b0;

    always @(posedge clk) begin : model
        logic [31:0] old_pc;
        bit          nd, ne;
        old_pc = m_pc;
        nd = 1'b0;
        ne = 1'b0;
        if (rst) begin
            m_pc = 32'h0; m_instr = 32'h0; m_addr = 32'h0;
            m_req = 1'b0; m_gap = 1'b0; m_waited = 0;
            m_valid = 1'b1;
        end else begin
            if (PCWrite || (PCWriteCond && Zero)) begin
                case (PCSource)
                    2'd0: m_pc = alu_result;
                    2'd1: m_pc = alu_out;
                    2'd2: m_pc = {old_pc[31:28], m_instr[25:0], 2'b00};
                    default: m_pc = old_pc;
                endcase
            end
            if (m_req) begin
                m_waited++;
                if (mem_ack) begin
                    m_instr = mem_rdata;
                    m_req   = 1'b0;
                    m_gap   = 1'b1;
                end else if (TO_EN && m_waited >= TIMEOUT) begin
                    m_req = 1'b0;
                    ne    = 1'b1;
                end
            end else if (m_gap) begin
                m_gap = 1'b0;
                nd    = 1'b1;
            end else if (IRWrite) begin
                if (old_pc[1:0] == 2'b00) begin
                    m_req    = 1'b1;
                    m_addr   = old_pc;
                    m_waited = 0;
                end else begin
                    ne = 1'b1;
                end
            end
        end
        m_done = nd;
        m_err  = ne;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            cmp32("m_pc", pc, m_pc);
            cmp32("m_instr", instr, m_instr);
            cmp1("m_mem_req", mem_req, m_req);
            cmp1("m_fetch_busy", fetch_busy, m_req);
            cmp1("m_fetch_done", fetch_done, m_done);
            cmp1("m_fetch_err", fetch_err, m_err);
            cmp32("m_Op_code", 32'(Op_code), 32'(m_instr[31:26]));
            cmp32("m_Funct", 32'(Funct), 32'(m_instr[5:0]));
            if (m_req) cmp32("m_mem_addr", mem_addr, m_addr);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string nm);
        int k;
        k = 0;
        while (fetch_done !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        cmp1({nm, "_done_seen"}, fetch_done, 1'b1);
    endtask

    logic [31:0] cur_pc;

    initial begin
        rst = 1'b1; IRWrite = 1'b0; PCWrite = 1'b0; PCWriteCond = 1'b0; Zero = 1'b0;
        PCSource = 2'd0; alu_result = 32'h0; alu_out = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;

        // reset
        step(); step();
        cmp32("rst_pc", pc, 32'h0);
        cmp32("rst_instr", instr, 32'h0);
        cmp32("rst_mem_addr", mem_addr, 32'h0);
        cmp1("rst_mem_req", mem_req, 1'b0);
        cmp1("rst_busy", fetch_busy, 1'b0);
        cmp1("rst_done", fetch_done, 1'b0);
        cmp1("rst_err", fetch_err, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            cmp1("idle_no_req", mem_req, 1'b0);
        end

        // basic fetch with PC increment on the same edge
        IRWrite = 1'b1; PCWrite = 1'b1; PCSource = 2'd0; alu_result = 32'h4;
        step();
        IRWrite = 1'b0; PCWrite = 1'b0;
        cmp1("basic_req", mem_req, 1'b1);
        cmp32("basic_addr", mem_addr, 32'h0);
        cmp32("basic_pc", pc, 32'h4);
        step(); step();
        mem_ack = 1'b1; mem_rdata = 32'h0143_4820;
        step();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        cmp32("basic_instr", instr, 32'h0143_4820);
        cmp1("basic_req_drop", mem_req, 1'b0);
        cmp1("basic_done_early", fetch_done, 1'b0);
        step();
        cmp1("basic_done", fetch_done, 1'b1);
        cmp32("basic_op", 32'(Op_code), 32'h0);
        cmp32("basic_funct", 32'(Funct), 32'h20);
        step();
        cmp1("basic_done_once", fetch_done, 1'b0);

        // conditional branch
        PCWriteCond = 1'b1; Zero = 1'b0; PCSource = 2'd1; alu_out = 32'h40;
        step();
        cmp32("beq_not_taken", pc, 32'h4);
        Zero = 1'b1;
        step();
        PCWriteCond = 1'b0; Zero = 1'b0;
        cmp32("beq_taken", pc, 32'h40);

        // fastest fetch: ack on the first request cycle
        IRWrite = 1'b1;
        step();
        IRWrite = 1'b0;
        cmp32("jfetch_addr", mem_addr, 32'h40);
        mem_ack = 1'b1; mem_rdata = 32'h0800_0010;
        step();
        mem_ack = 1'b0;
        cmp32("jfetch_instr", instr, 32'h0800_0010);
        step();
        cmp1("jfetch_done_cycle3", fetch_done, 1'b1);

        // jump, hold, and jump keeping the upper PC nibble
        PCWrite = 1'b1; PCSource = 2'd0; alu_result = 32'h100;
        step();
        cmp32("pc_load", pc, 32'h100);
        PCSource = 2'd3;
        step();
        cmp32("pc_hold", pc, 32'h100);
        PCSource = 2'd2;
        step();
        cmp32("jump", pc, 32'h0000_0040);
        PCSource = 2'd0; alu_result = 32'hF000_0000;
        step();
        PCSource = 2'd2;
        step();
        PCWrite = 1'b0;
        cmp32("jump_hi", pc, 32'hF000_0040);

        // misaligned PC
        PCWrite = 1'b1; PCSource = 2'd0; alu_result = 32'h6;
        step();
        PCWrite = 1'b0;
        cmp32("mis_pc", pc, 32'h6);
        IRWrite = 1'b1;
        step();
        IRWrite = 1'b0;
        cmp1("mis_err", fetch_err, 1'b1);
        cmp1("mis_no_req", mem_req, 1'b0);
        step();
        cmp1("mis_err_once", fetch_err, 1'b0);
        cmp1("mis_still_no_req", mem_req, 1'b0);

        // variable latency, IRWrite held through WAIT and DONE, PC advancing
        PCWrite = 1'b1; alu_result = 32'h8;
        step();
        PCWrite = 1'b0;
        cur_pc = 32'h8;
        for (int lat = 0; lat < 4; lat++) begin
            IRWrite = 1'b1; PCWrite = 1'b1; PCSource = 2'd0; alu_result = cur_pc + 32'h4;
            step();
            PCWrite = 1'b0;
            cmp32("lat_addr", mem_addr, cur_pc);
            for (int w = 0; w < lat; w++) step();
            mem_ack = 1'b1; mem_rdata = 32'h2000_0100 + 32'(lat);
            step();
            mem_ack = 1'b0;
            cmp32("lat_instr", instr, 32'h2000_0100 + 32'(lat));
            step();
            IRWrite = 1'b0;
            cmp1("lat_done", fetch_done, 1'b1);
            cmp1("lat_irwrite_in_done_ignored", mem_req, 1'b0);
            cur_pc = cur_pc + 32'h4;
            step();
        end

        // reset during a fetch, then stray acks
        IRWrite = 1'b1;
        step();
        IRWrite = 1'b0;
        cmp1("abort_req", mem_req, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        cmp1("abort_req_drop", mem_req, 1'b0);
        cmp32("abort_pc", pc, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_ack = 1'b0;
        cmp32("late_ack_instr", instr, 32'h0);
        step();
        cmp1("late_ack_no_done", fetch_done, 1'b0);

        // long wait (and timeout when enabled)
        IRWrite = 1'b1;
        step();
        IRWrite = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        step(); step(); step();
        cmp1("to_req_held", mem_req, 1'b1);
        step();
        cmp1("to_req_drop", mem_req, 1'b0);
        cmp1("to_err", fetch_err, 1'b1);
        cmp32("to_instr_kept", instr, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        mem_ack = 1'b0;
        cmp1("to_err_once", fetch_err, 1'b0);
        cmp32("to_late_ack", instr, 32'h0);
`else
        for (int i = 0; i < 20; i++) step();
        cmp1("long_wait_req", mem_req, 1'b1);
        cmp1("long_wait_no_err", fetch_err, 1'b0);
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        mem_ack = 1'b0;
        wait_done("long_wait");
        cmp32("long_wait_instr", instr, 32'h1234_5678);
`endif
        step();
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        step();
        mem_ack = 1'b0;
        cmp1("idle_ack_no_req", mem_req, 1'b0);
`ifdef FETCH_TIMEOUT_EN
        cmp32("idle_ack_instr", instr, 32'h0);
`else
        cmp32("idle_ack_instr", instr, 32'h1234_5678);
`endif
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, limit 200000 ns");
        $fatal(1, "time limit");
    end

endmodule
